// File: rtl/ball_motion_engine.sv
// Ball kinematics for the PingPong playfield: serve, per-frame motion, wall/paddle
// reflection, speed-up and goal detection. Define BALL_SPIN_EN to let paddle_offset steer vy.
module ball_motion_engine #(
   parameter int          FIELD_W          = 64,
   parameter int          FIELD_H          = 64,
   parameter int          POS_W            = 8,
   parameter int          VEL_W            = 4,
   parameter int          VX_INIT          = 2,
   parameter int          VX_MAX           = 6,
   parameter int          HITS_PER_SPEEDUP = 4,
   parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_tick,
   input  logic             serve,
   input  logic             serve_dir,
   input  logic             paddle_hit_l,
   input  logic             paddle_hit_r,
   input  logic [1:0]       paddle_offset,
   output logic [POS_W-1:0] bx,
   output logic [POS_W-1:0] by,
   output logic             bx_dir,
   output logic             by_dir,
   output logic [VEL_W-1:0] vx_mag,
   output logic [VEL_W-1:0] vy_mag,
   output logic [1:0]       state,
   output logic             goal_l,
   output logic             goal_r
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SERVE = 2'd1;
   localparam logic [1:0] ST_MOVE  = 2'd2;
   localparam logic [1:0] ST_SCORE = 2'd3;

   localparam int HIT_W = (HITS_PER_SPEEDUP < 2) ? 1 : $clog2(HITS_PER_SPEEDUP + 1);

   localparam logic [POS_W-1:0] X_CTR     = POS_W'(FIELD_W / 2);
   localparam logic [POS_W-1:0] Y_CTR     = POS_W'(FIELD_H / 2);
   localparam logic [POS_W:0]   X_LIM     = (POS_W+1)'(FIELD_W - 1);
   localparam logic [POS_W:0]   Y_LIM     = (POS_W+1)'(FIELD_H - 1);
   localparam logic [VEL_W-1:0] VX_INIT_V = VEL_W'(VX_INIT);
   localparam logic [VEL_W-1:0] VX_MAX_V  = VEL_W'(VX_MAX);
   localparam logic [HIT_W-1:0] HITS_V    = HIT_W'(HITS_PER_SPEEDUP);

   logic [1:0]       state_q, state_d;
   logic [POS_W-1:0] bx_q, bx_d, by_q, by_d;
   logic             bx_dir_q, bx_dir_d, by_dir_q, by_dir_d;
   logic [VEL_W-1:0] vx_q, vx_d, vy_q, vy_d;
   logic [HIT_W-1:0] hits_q, hits_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic             goal_l_q, goal_l_d, goal_r_q, goal_r_d;

   logic             ret;
   logic             goal_left, goal_right;
   logic [POS_W:0]   bx_ext, by_ext, vx_ext, vy_ext;
   logic [VEL_W-1:0] vy_n;
   logic             ydir_n;

`ifdef BALL_SPIN_EN
   logic signed [VEL_W+1:0] vy_spin;
`else
   logic unused_offset;
   assign unused_offset = ^paddle_offset;
`endif

   // Only the paddle the ball is travelling toward can return it; a return masks any goal.
   assign ret        = bx_dir_q ? paddle_hit_r : paddle_hit_l;
   assign bx_ext     = {1'b0, bx_q};
   assign vx_ext     = (POS_W+1)'(vx_q);
   assign goal_left  = !ret && !bx_dir_q && (bx_ext < vx_ext);
   assign goal_right = !ret &&  bx_dir_q && ((bx_ext + vx_ext) > X_LIM);

   always_comb begin
      state_d  = state_q;
      bx_d     = bx_q;
      by_d     = by_q;
      bx_dir_d = bx_dir_q;
      by_dir_d = by_dir_q;
      vx_d     = vx_q;
      vy_d     = vy_q;
      hits_d   = hits_q;
      goal_l_d = 1'b0;
      goal_r_d = 1'b0;
      lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      vy_n     = vy_q;
      ydir_n   = by_dir_q;
      by_ext   = {1'b0, by_q};
      vy_ext   = '0;
`ifdef BALL_SPIN_EN
      vy_spin  = '0;
`endif

      case (state_q)
         ST_IDLE: begin
            bx_d = X_CTR;
            by_d = Y_CTR;
            if (serve) state_d = ST_SERVE;
         end

         ST_SERVE: begin
            vx_d     = VX_INIT_V;
            vy_d     = (lfsr_q[1:0] == 2'd3) ? VEL_W'(1) : VEL_W'(lfsr_q[1:0]) + VEL_W'(1);
            by_dir_d = lfsr_q[2];
            bx_dir_d = serve_dir;
            hits_d   = '0;
            state_d  = ST_MOVE;
         end

         ST_MOVE: begin
            if (frame_tick) begin
               if (ret) begin
                  bx_dir_d = ~bx_dir_q;
                  if (HITS_PER_SPEEDUP != 0) begin
                     if (hits_q + HIT_W'(1) == HITS_V) begin
                        hits_d = '0;
                        vx_d   = (vx_q >= VX_MAX_V) ? VX_MAX_V : vx_q + VEL_W'(1);
                     end else begin
                        hits_d = hits_q + HIT_W'(1);
                     end
                  end
`ifdef BALL_SPIN_EN
                  vy_spin = $signed({2'b00, vy_q}) + (VEL_W+2)'($signed(paddle_offset));
                  if (vy_spin < $signed((VEL_W+2)'(1)))      vy_n = VEL_W'(1);
                  else if (vy_spin > $signed((VEL_W+2)'(3))) vy_n = VEL_W'(3);
                  else                                       vy_n = vy_spin[VEL_W-1:0];
                  if (paddle_offset != 2'b00) ydir_n = ~paddle_offset[1];
`endif
               end else if (goal_left) begin
                  goal_l_d = 1'b1;
                  state_d  = ST_SCORE;
               end else if (goal_right) begin
                  goal_r_d = 1'b1;
                  state_d  = ST_SCORE;
               end else begin
                  bx_d = bx_dir_q ? bx_q + POS_W'(vx_q) : bx_q - POS_W'(vx_q);
               end

               // Y uses the post-return speed/direction; a scoring tick freezes the ball.
               vy_d     = vy_n;
               by_dir_d = ydir_n;
               vy_ext   = (POS_W+1)'(vy_n);
               if (!goal_left && !goal_right) begin
                  if (!ydir_n && (by_ext < vy_ext)) begin
                     by_d     = '0;
                     by_dir_d = 1'b1;
                  end else if (ydir_n && ((by_ext + vy_ext) > Y_LIM)) begin
                     by_d     = Y_LIM[POS_W-1:0];
                     by_dir_d = 1'b0;
                  end else begin
                     by_d = ydir_n ? by_q + POS_W'(vy_n) : by_q - POS_W'(vy_n);
                  end
               end
            end
         end

         default: begin
            if (frame_tick) begin
               state_d = ST_IDLE;
               bx_d    = X_CTR;
               by_d    = Y_CTR;
               vx_d    = '0;
               vy_d    = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         bx_q     <= X_CTR;
         by_q     <= Y_CTR;
         bx_dir_q <= 1'b0;
         by_dir_q <= 1'b0;
         vx_q     <= '0;
         vy_q     <= '0;
         hits_q   <= '0;
         lfsr_q   <= LFSR_SEED;
         goal_l_q <= 1'b0;
         goal_r_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         bx_q     <= bx_d;
         by_q     <= by_d;
         bx_dir_q <= bx_dir_d;
         by_dir_q <= by_dir_d;
         vx_q     <= vx_d;
         vy_q     <= vy_d;
         hits_q   <= hits_d;
         lfsr_q   <= lfsr_d;
         goal_l_q <= goal_l_d;
         goal_r_q <= goal_r_d;
      end
   end

   assign bx     = bx_q;
   assign by     = by_q;
   assign bx_dir = bx_dir_q;
   assign by_dir = by_dir_q;
   assign vx_mag = vx_q;
   assign vy_mag = vy_q;
   assign state  = state_q;
   assign goal_l = goal_l_q;
   assign goal_r = goal_r_q;

endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed bench for ball_motion_engine: an integer-arithmetic model checked every cycle
// plus literal expectations at key points of scripted rallies.
module tb_ball_motion_engine;

   localparam int FW = 64, FH = 64, PW = 8, VW = 4;
   localparam int VXI = 2, VXM = 6, HPS = 4;
   localparam logic [15:0] SEED = 16'hACE1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          frame_tick = 1'b0, serve = 1'b0, serve_dir = 1'b0;
   logic          paddle_hit_l = 1'b0, paddle_hit_r = 1'b0;
   logic [1:0]    paddle_offset = 2'b00;
   logic [PW-1:0] bx, by;
   logic          bx_dir, by_dir;
   logic [VW-1:0] vx_mag, vy_mag;
   logic [1:0]    state;
   logic          goal_l, goal_r;

   int n_checks = 0;
   int n_err    = 0;

   ball_motion_engine #(
      .FIELD_W(FW), .FIELD_H(FH), .POS_W(PW), .VEL_W(VW),
      .VX_INIT(VXI), .VX_MAX(VXM), .HITS_PER_SPEEDUP(HPS), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .serve(serve), .serve_dir(serve_dir),
      .paddle_hit_l(paddle_hit_l), .paddle_hit_r(paddle_hit_r), .paddle_offset(paddle_offset),
      .bx(bx), .by(by), .bx_dir(bx_dir), .by_dir(by_dir), .vx_mag(vx_mag), .vy_mag(vy_mag),
      .state(state), .goal_l(goal_l), .goal_r(goal_r)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: states 0 idle, 1 serve, 2 move, 3 score; plain integers throughout
   int m_state, m_bx, m_by, m_xd, m_yd, m_vx, m_vy, m_hits, m_gl, m_gr;
   int m_lfsr;
   bit m_valid = 1'b0;

   always @(posedge clk) begin
      int lf, fb, ny, off;
      bit rt, gl, gr;
      if (!reset) begin
         m_state = 0; m_bx = FW / 2; m_by = FH / 2; m_xd = 0; m_yd = 0;
         m_vx = 0; m_vy = 0; m_hits = 0; m_gl = 0; m_gr = 0;
         m_lfsr = int'(SEED); m_valid = 1'b1;
      end else begin
         lf = m_lfsr;
         fb = ((lf >> 0) ^ (lf >> 2) ^ (lf >> 3) ^ (lf >> 5)) & 1;
         m_lfsr = (lf >> 1) | (fb << 15);
         m_gl = 0; m_gr = 0;
         case (m_state)
            0: if (serve) m_state = 1;
            1: begin
               m_vx = VXI;
               m_vy = 1 + ((lf % 4) % 3);
               m_yd = (lf >> 2) & 1;
               m_xd = int'(serve_dir);
               m_hits = 0;
               m_state = 2;
            end
            2: if (frame_tick) begin
               rt = (m_xd == 1) ? paddle_hit_r : paddle_hit_l;
               gl = !rt && m_xd == 0 && m_bx < m_vx;
               gr = !rt && m_xd == 1 && m_bx + m_vx > FW - 1;
               if (rt) begin
                  m_xd = 1 - m_xd;
                  m_hits++;
                  if (HPS != 0 && m_hits == HPS) begin
                     m_hits = 0;
                     m_vx = (m_vx + 1 > VXM) ? VXM : m_vx + 1;
                  end
`ifdef BALL_SPIN_EN
                  off = paddle_offset[1] ? int'(paddle_offset) - 4 : int'(paddle_offset);
                  m_vy = m_vy + off;
                  if (m_vy < 1) m_vy = 1;
                  if (m_vy > 3) m_vy = 3;
                  if (off != 0) m_yd = (off > 0) ? 1 : 0;
`endif
               end else if (gl) begin
                  m_gl = 1; m_state = 3;
               end else if (gr) begin
                  m_gr = 1; m_state = 3;
               end else begin
                  m_bx = (m_xd == 1) ? m_bx + m_vx : m_bx - m_vx;
               end
               if (!gl && !gr) begin
                  ny = (m_yd == 1) ? m_by + m_vy : m_by - m_vy;
                  if (ny < 0) begin m_by = 0; m_yd = 1; end
                  else if (ny > FH - 1) begin m_by = FH - 1; m_yd = 0; end
                  else m_by = ny;
               end
            end
            default: if (frame_tick) begin
               m_state = 0; m_bx = FW / 2; m_by = FH / 2; m_vx = 0; m_vy = 0;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("cyc_state", 32'(state), m_state);
         chk("cyc_bx", 32'(bx), m_bx);
         chk("cyc_by", 32'(by), m_by);
         chk("cyc_bx_dir", 32'(bx_dir), m_xd);
         chk("cyc_by_dir", 32'(by_dir), m_yd);
         chk("cyc_vx", 32'(vx_mag), m_vx);
         chk("cyc_vy", 32'(vy_mag), m_vy);
         chk("cyc_goal_l", 32'(goal_l), m_gl);
         chk("cyc_goal_r", 32'(goal_r), m_gr);
      end
   end

   int tick_n = 0;

   // One frame tick then a gap cycle with both hit levels high, which must be ignored.
   task automatic tick_frame(input logic hl, input logic hr, output logic gl, output logic gr);
      frame_tick = 1'b1; paddle_hit_l = hl; paddle_hit_r = hr;
      paddle_offset = 2'(tick_n % 3);
      tick_n++;
      @(posedge clk); #1;
      gl = goal_l; gr = goal_r;
      frame_tick = 1'b0; paddle_hit_l = 1'b1; paddle_hit_r = 1'b1;
      @(posedge clk); #1;
      paddle_hit_l = 1'b0; paddle_hit_r = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic gl, gr;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", 32'(state), 0);
      chk("rst_bx", 32'(bx), 32);
      chk("rst_by", 32'(by), 32);
      chk("rst_vx", 32'(vx_mag), 0);
      chk("rst_goals", 32'({goal_l, goal_r}), 0);

      // Serve right; LFSR is 16'h5670 during SERVE so vy=1 and by_dir=0
      reset = 1'b1; serve = 1'b1; serve_dir = 1'b1;
      @(posedge clk); #1;
      chk("serve_state", 32'(state), 1);
      serve = 1'b0; frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      chk("move_state", 32'(state), 2);
      chk("serve_bx", 32'(bx), 32);
      chk("serve_vx", 32'(vx_mag), 2);
      chk("serve_vy", 32'(vy_mag), 1);
      chk("serve_by_dir", 32'(by_dir), 0);
      chk("serve_bx_dir", 32'(bx_dir), 1);

      for (int i = 0; i < 20; i++) begin
         if (i == 5) serve = 1'b1;
         tick_frame((i % 2 == 1) || (i % 4 == 0), i % 2 == 0, gl, gr);
         serve = 1'b0;
         if (i == 3) chk("speedup_4", 32'(vx_mag), 3);
      end
      chk("sat_vx", 32'(vx_mag), 6);
      chk("rally1_bx", 32'(bx), 32);
      chk("rally1_by", 32'(by), 12);
      chk("rally1_dir", 32'(bx_dir), 1);

      tick_frame(1'b1, 1'b0, gl, gr);
      chk("away_hit_bx", 32'(bx), 38);
      chk("away_hit_by", 32'(by), 11);

      for (int k = 0; k < 5; k++) begin
         tick_frame(1'b0, 1'b0, gl, gr);
         chk("goal_r_pulse", 32'(gr), (k == 4) ? 1 : 0);
      end
      chk("goal_r_state", 32'(state), 3);
      chk("goal_r_bx", 32'(bx), 62);
      chk("goal_r_by", 32'(by), 7);
      tick_frame(1'b0, 1'b0, gl, gr);
      chk("score_idle", 32'(state), 0);
      chk("score_bx", 32'(bx), 32);
      chk("score_by", 32'(by), 32);
      chk("score_v", 32'({vx_mag, vy_mag}), 0);

      // Second serve left; long rally forces wall bounces
      serve = 1'b1; serve_dir = 1'b0;
      @(posedge clk); #1;
      serve = 1'b0;
      @(posedge clk); #1;
      chk("serve2_dir", 32'(bx_dir), 0);
      chk("serve2_vy_range", 32'((vy_mag >= 1) && (vy_mag <= 3)), 1);
      for (int i = 0; i < 100; i++) tick_frame(i % 2 == 0, i % 2 == 1, gl, gr);
      chk("rally2_bx", 32'(bx), 32);
      chk("rally2_vx", 32'(vx_mag), 6);
      for (int k = 0; k < 5; k++) tick_frame(1'b0, 1'b0, gl, gr);
      chk("edge_bx", 32'(bx), 2);
      tick_frame(1'b1, 1'b0, gl, gr);
      chk("return_wins", 32'(gl), 0);
      chk("return_bx", 32'(bx), 2);
      chk("return_dir", 32'(bx_dir), 1);
      tick_frame(1'b0, 1'b1, gl, gr);
      tick_frame(1'b0, 1'b0, gl, gr);
      chk("goal_l_pulse", 32'(gl), 1);
      chk("goal_l_state", 32'(state), 3);
      tick_frame(1'b0, 1'b0, gl, gr);

      // Reset mid-rally
      serve = 1'b1; serve_dir = 1'b1;
      @(posedge clk); #1;
      serve = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) tick_frame(1'b0, 1'b0, gl, gr);
      chk("pre_rst_bx", 32'(bx), 38);
      reset = 1'b0; frame_tick = 1'b1;
      @(posedge clk); #1;
      chk("midrst_state", 32'(state), 0);
      chk("midrst_bx", 32'(bx), 32);
      chk("midrst_goals", 32'({goal_l, goal_r}), 0);
      reset = 1'b1; frame_tick = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/ball_motion_engine.md
# ball_motion_engine

Parametrised ball kinematics engine for the PingPong playfield. Holds ball position and signed velocity, serves the ball from centre with an LFSR-chosen vertical speed, advances position once per frame strobe, reflects off top/bottom walls and paddles, speeds the ball up after a configurable number of returns, and flags goals. It sits between the collision detectors and the renderer/score logic.

## Interface

- FIELD_W, 64: playfield width in pixels; x range 0..FIELD_W-1
- FIELD_H, 64: playfield height in pixels; y range 0..FIELD_H-1
- POS_W, 8: coordinate width; must satisfy 2^POS_W >= max(FIELD_W, FIELD_H)
- VEL_W, 4: unsigned velocity-magnitude width
- VX_INIT, 2: horizontal speed at serve, in pixels per frame
- VX_MAX, 6: horizontal speed saturation value
- HITS_PER_SPEEDUP, 4: paddle returns per +1 increment of vx; 0 disables speed-up
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero

- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle strobe, once per video frame
- serve  in  1  serve request; accepted only in IDLE
- serve_dir  in  1  initial x direction: 0 = toward left, 1 = toward right
- paddle_hit_l  in  1  left paddle overlaps ball; level, sampled on frame_tick
- paddle_hit_r  in  1  right paddle overlaps ball; level, sampled on frame_tick
- paddle_offset  in  2  signed contact zone on the hitting paddle, range -1..+1; used only when BALL_SPIN_EN is defined
- bx, by  out  POS_W  ball position
- bx_dir, by_dir  out  1  direction: 1 = +x / +y, 0 = -x / -y
- vx_mag, vy_mag  out  VEL_W  current speed magnitudes
- state  out  2  IDLE=0, SERVE=1, MOVE=2, SCORE=3
- goal_l  out  1  one-cycle pulse: ball exited the left edge, so the right player scores
- goal_r  out  1  one-cycle pulse: ball exited the right edge, so the left player scores

## Operation

- Reset values, applied while reset is low:
  - state = IDLE
  - bx = FIELD_W/2, by = FIELD_H/2
  - bx_dir = 0, by_dir = 0
  - vx_mag = 0, vy_mag = 0
  - goals = 0
  - hit counter = 0
  - LFSR = LFSR_SEED
- Reset asserted mid-rally aborts the rally immediately. No goal pulse is produced.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11. Advances every clk cycle when not in reset.
- IDLE:
  - Ball is held at centre.
  - `serve` moves the engine to SERVE.
- SERVE (exactly 1 cycle):
  - vx_mag = VX_INIT
  - vy_mag = 1 + (lfsr[1:0] mod 3), giving a value in 1..3
  - by_dir = lfsr[2]
  - bx_dir = serve_dir
  - hit counter cleared
  - Next state MOVE. A frame_tick arriving in this cycle is ignored.
- MOVE, on each frame_tick, evaluated in this priority order:
  1. Paddle:
     - A return is `paddle_hit_l` while bx_dir=0, or `paddle_hit_r` while bx_dir=1. On a return, invert bx_dir and do not move x this frame.
     - Hit counter increments on each return. When it reaches HITS_PER_SPEEDUP, it clears and vx_mag = min(vx_mag+1, VX_MAX).
     - A hit signal on the paddle the ball is moving away from is ignored.
  2. Goal:
     - No return and bx_dir=0 and bx < vx_mag: pulse goal_l, go to SCORE.
     - No return and bx_dir=1 and bx + vx_mag > FIELD_W-1: pulse goal_r, go to SCORE.
     - Position is frozen at its last value.
  3. Otherwise, bx = bx ± vx_mag.
  4. Y axis, evaluated every tick independent of x:
     - Compute ny = by ± vy_mag in POS_W+1 signed bits.
     - ny < 0: by = 0, by_dir = 1.
     - ny > FIELD_H-1: by = FIELD_H-1, by_dir = 0.
     - Otherwise by = ny.
- SCORE:
  - Stays in SCORE until the next frame_tick.
  - On that tick: return to IDLE and re-centre the ball; vx_mag and vy_mag go to 0.
  - goal_l/goal_r are high only in the cycle that state enters SCORE.

## Timing

- Position and direction outputs update in the cycle after frame_tick is sampled, and are registered.
- Serve latency:
  - serve sampled at cycle n: state=SERVE at n+1, state=MOVE at n+2.
  - First motion happens on the first frame_tick sampled at n+2 or later.
- Goal pulse is asserted in the cycle after the offending frame_tick, width exactly 1 cycle.
- Simultaneous return and goal condition on the same tick: the return wins, no goal.
- serve in any state other than IDLE is ignored.
- All arithmetic is unsigned magnitude plus a direction bit. Intermediate sums use POS_W+1 bits, so no wrap-around is possible.

## Configuration

- BALL_SPIN_EN defined:
  - On a return, vy_mag = clamp(vy_mag + paddle_offset, 1, 3).
  - If paddle_offset is non-zero, by_dir is set to its sign.
- BALL_SPIN_EN undefined:
  - paddle_offset is ignored; vy_mag and by_dir are unchanged by paddle hits.
  - The port remains present.

## Test plan

- Reset then serve with serve_dir=1, LFSR_SEED default: state goes IDLE→SERVE→MOVE on consecutive cycles; bx=32, vx_mag=2, vy_mag∈1..3.
- Wall bounce: by=1, by_dir=0, vy_mag=3 on tick → by=0, by_dir=1; symmetric case at the bottom → by=63, by_dir=0.
- Left paddle return: bx=1, bx_dir=0, paddle_hit_l=1 on tick → bx_dir=1, bx=1, no goal_l; paddle_hit_r at the same time is ignored.
- Speed-up: 4 consecutive returns → vx_mag 2→3; 16 more returns → saturates at 6.
- Goal: bx=1, vx_mag=2, bx_dir=0, no hit → goal_l one-cycle pulse, SCORE; next tick → IDLE at (32,32).
- Reset low mid-MOVE → next cycle state=IDLE, centred, no goal pulse. With BALL_SPIN_EN: return with paddle_offset=+1 and vy_mag=3 → vy_mag stays 3, by_dir=1.
